// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi decoder frame controller.
// Symbol width, trellis size and the controller state encoding live here.
// Build option VITERBI_CTRL_ABORT_EN (used by the interface and top) adds an abort input.
package viterbi_pkg;

  localparam int SYM_W      = 2;
  localparam int NUM_STATES = 4;

  typedef logic [SYM_W-1:0] sym_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ACS,
    ST_DRAIN,
    ST_TB,
    ST_DONE
  } ctrl_state_e;

endpackage

// File: rtl/viterbi_ctrl_if.sv
// Symbol handshake and datapath control bundle for viterbi_ctrl.
// slave modport is the controller side, master modport the source/datapath side.
// Build option VITERBI_CTRL_ABORT_EN adds the i_abort request line.
interface viterbi_ctrl_if #(
  parameter int ADDR_W = 4
);
  import viterbi_pkg::*;

  logic              i_start;
  logic              i_sym_valid;
  sym_t              i_sym;
`ifdef VITERBI_CTRL_ABORT_EN
  logic              i_abort;
`endif
  logic              o_sym_ready;
  sym_t              o_bmu_data;
  logic              o_acs_init;
  logic              o_acs_en;
  logic              o_sm_wr_en;
  logic [ADDR_W-1:0] o_sm_addr;
  logic              o_tb_en;
  logic              o_busy;
  logic              o_done;

  modport slave (
    input  i_start, i_sym_valid, i_sym,
`ifdef VITERBI_CTRL_ABORT_EN
    input  i_abort,
`endif
    output o_sym_ready, o_bmu_data, o_acs_init, o_acs_en, o_sm_wr_en,
    output o_sm_addr, o_tb_en, o_busy, o_done
  );

  modport master (
    output i_start, i_sym_valid, i_sym,
`ifdef VITERBI_CTRL_ABORT_EN
    output i_abort,
`endif
    input  o_sym_ready, o_bmu_data, o_acs_init, o_acs_en, o_sm_wr_en,
    input  o_sm_addr, o_tb_en, o_busy, o_done
  );

endinterface

// File: rtl/viterbi_addr_cnt.sv
// Survivor-memory address register with clear, load, up and down controls.
// Registered output, updates one cycle after the control is applied.
// Priority clear > load > up > down; terminal flags are combinational from the register.
module viterbi_addr_cnt #(
  parameter int FRAME_LEN = 16,
  parameter int ADDR_W    = $clog2(FRAME_LEN)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  input  logic              i_up,
  input  logic              i_down,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_tc_zero,
  output logic              o_tc_last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  logic [ADDR_W-1:0] r_addr;

  // Address register; the caller gates up/down with the terminal flags so it never wraps.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr <= '0;
    end else if (i_clr) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_load_val;
    end else if (i_up) begin
      r_addr <= r_addr + 1'b1;
    end else if (i_down) begin
      r_addr <= r_addr - 1'b1;
    end
  end

  assign o_addr    = r_addr;
  assign o_tc_zero = (r_addr == '0);
  assign o_tc_last = (r_addr == LAST_ADDR);

endmodule

// File: rtl/viterbi_ctrl.sv
// Frame sequencer: INIT, symbol accept with ACS/survivor strobes, DRAIN, traceback, DONE.
// Accepted symbol appears on o_bmu_data with its ACS strobe one cycle after the handshake.
// o_sym_ready only in ACS while symbols remain; VITERBI_CTRL_ABORT_EN adds i_abort.
module viterbi_ctrl #(
  parameter int FRAME_LEN = 16,
  parameter int ADDR_W    = $clog2(FRAME_LEN)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  viterbi_ctrl_if.slave bus
);
  import viterbi_pkg::*;

  localparam int                CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_END  = CNT_W'(FRAME_LEN);
  localparam logic [ADDR_W-1:0] TB_START = ADDR_W'(FRAME_LEN - 1);

  ctrl_state_e       r_state;
  ctrl_state_e       w_next;
  logic [CNT_W-1:0]  r_cnt;
  sym_t              r_bmu_data;
  logic              r_acs_en;
  logic              w_abort;
  logic              w_sym_ready;
  logic              w_hs;
  logic              w_clr;
  logic              w_load;
  logic              w_up;
  logic              w_down;
  logic [ADDR_W-1:0] w_addr;
  logic              w_tc_zero;
  logic              w_tc_last;

`ifdef VITERBI_CTRL_ABORT_EN
  assign w_abort = bus.i_abort && (r_state != ST_IDLE) && (r_state != ST_DONE);
`else
  assign w_abort = 1'b0;
`endif

  // An abort wins over a same-cycle handshake, so ready is withdrawn with it.
  assign w_sym_ready = (r_state == ST_ACS) && (r_cnt < CNT_END) && !w_abort;
  assign w_hs        = w_sym_ready && bus.i_sym_valid;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state and address-counter controls.
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_load = 1'b0;
    w_up   = 1'b0;
    w_down = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_start) w_next = ST_INIT;
      end
      ST_INIT: begin
        w_clr  = 1'b1;
        w_next = ST_ACS;
      end
      ST_ACS: begin
        if (w_hs) begin
          // The first symbol uses the cleared address 0; later ones step it.
          w_up = (r_cnt != '0) && !w_tc_last;
          if (r_cnt == CNT_LAST) w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_load = 1'b1;
        w_next = ST_TB;
      end
      ST_TB: begin
        if (w_tc_zero) begin
          w_clr  = 1'b1;
          w_next = ST_DONE;
        end else begin
          w_down = 1'b1;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
    if (w_abort) begin
      w_next = ST_IDLE;
      w_clr  = 1'b1;
      w_load = 1'b0;
      w_up   = 1'b0;
      w_down = 1'b0;
    end
  end

  // Symbol counter: cleared at frame start, counts accepted symbols.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                    r_cnt <= '0;
    else if (r_state == ST_INIT)  r_cnt <= '0;
    else if (w_hs)                r_cnt <= r_cnt + 1'b1;
  end

  // Symbol register and ACS strobe; data holds across valid gaps.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bmu_data <= '0;
      r_acs_en   <= 1'b0;
    end else begin
      r_acs_en <= w_hs;
      if (w_hs) r_bmu_data <= bus.i_sym;
    end
  end

  viterbi_addr_cnt #(
    .FRAME_LEN (FRAME_LEN),
    .ADDR_W    (ADDR_W)
  ) u_addr_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (w_clr),
    .i_load     (w_load),
    .i_load_val (TB_START),
    .i_up       (w_up),
    .i_down     (w_down),
    .o_addr     (w_addr),
    .o_tc_zero  (w_tc_zero),
    .o_tc_last  (w_tc_last)
  );

  assign bus.o_sym_ready = w_sym_ready;
  assign bus.o_bmu_data  = r_bmu_data;
  assign bus.o_acs_init  = (r_state == ST_INIT);
  assign bus.o_acs_en    = r_acs_en;
  assign bus.o_sm_wr_en  = r_acs_en;
  assign bus.o_sm_addr   = w_addr;
  assign bus.o_tb_en     = (r_state == ST_TB);
  assign bus.o_busy      = (r_state != ST_IDLE);
  assign bus.o_done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Scoreboard bench for viterbi_ctrl with FRAME_LEN=4.
// Stimulus pushes hand-computed events (cycle, data, address); a monitor pops them.
// Optional abort scenario is built when VITERBI_CTRL_ABORT_EN is defined.
module tb_viterbi_ctrl;
  import viterbi_pkg::*;

  localparam int FL = 4;
  localparam int AW = 2;

  typedef struct { int cyc; logic [1:0] dat; logic [AW-1:0] addr; } strobe_t;
  typedef struct { int cyc; logic [AW-1:0] addr; } tb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  strobe_t sq[$];
  tb_t     tq[$];
  int      iq[$];
  int      dq[$];

  viterbi_ctrl_if #(.ADDR_W(AW)) bus ();

  viterbi_ctrl #(.FRAME_LEN(FL), .ADDR_W(AW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [10:0] outs();
    return {bus.o_sym_ready, bus.o_bmu_data, bus.o_acs_init, bus.o_acs_en, bus.o_sm_wr_en,
            bus.o_sm_addr, bus.o_tb_en, bus.o_busy, bus.o_done};
  endfunction

  task automatic push_strobe(input int c, input logic [1:0] d, input logic [AW-1:0] a);
    strobe_t s;
    s.cyc = c; s.dat = d; s.addr = a;
    sq.push_back(s);
  endtask

  task automatic push_tb(input int c, input logic [AW-1:0] a);
    tb_t t;
    t.cyc = c; t.addr = a;
    tq.push_back(t);
  endtask

  // Monitor: every presented event must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_acs_init) begin
        if (iq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL init_unexpected at cycle %0d", cyc);
        end else chk("init_cycle", cyc, iq.pop_front());
      end
      if (bus.o_acs_en || bus.o_sm_wr_en) begin
        if (sq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL strobe_unexpected at cycle %0d addr %0d", cyc, bus.o_sm_addr);
        end else begin
          strobe_t s;
          s = sq.pop_front();
          chk("strobe_cycle", cyc, s.cyc);
          chk("bmu_data", int'(bus.o_bmu_data), int'(s.dat));
          chk("wr_addr", int'(bus.o_sm_addr), int'(s.addr));
          chk("acs_en", int'(bus.o_acs_en), 1);
          chk("sm_wr_en", int'(bus.o_sm_wr_en), 1);
        end
      end
      if (bus.o_tb_en) begin
        if (tq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL tb_unexpected at cycle %0d addr %0d", cyc, bus.o_sm_addr);
        end else begin
          tb_t t;
          t = tq.pop_front();
          chk("tb_cycle", cyc, t.cyc);
          chk("tb_addr", int'(bus.o_sm_addr), int'(t.addr));
        end
      end
      if (bus.o_done) begin
        if (dq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL done_unexpected at cycle %0d", cyc);
        end else chk("done_cycle", cyc, dq.pop_front());
      end
    end
  end

  // Drives one frame starting from the current negedge (cycle 0 = i_start cycle).
  task automatic run_frame(input logic [31:0] vmask, input int start_again, input int abort_at,
                           input int rst_at, input logic gap, input int ncyc);
    logic [1:0] syms [4];
    int   idx;
    logic prev_hs;
    syms[0] = 2'b00; syms[1] = 2'b01; syms[2] = 2'b10; syms[3] = 2'b11;
    idx = 0;
    bus.i_start     = 1'b1;
    bus.i_sym_valid = vmask[0];
    bus.i_sym       = syms[0];
    #1 prev_hs = bus.o_sym_ready && bus.i_sym_valid;
    @(negedge clk);
    for (int c = 1; c < ncyc; c++) begin
      if (prev_hs && idx < 3) idx++;
      bus.i_start     = (c == start_again);
      bus.i_sym_valid = vmask[c];
      bus.i_sym       = syms[idx];
`ifdef VITERBI_CTRL_ABORT_EN
      bus.i_abort     = (c == abort_at);
`endif
      #1 prev_hs = bus.o_sym_ready && bus.i_sym_valid;
      if (gap && (c == 5 || c == 6)) chk("bmu_hold", int'(bus.o_bmu_data), 1);
      if (c == rst_at) begin
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_mid_outs", int'(outs()), 0);
        @(negedge clk);
        rst = 1'b0;
        break;
      end
      @(negedge clk);
    end
    bus.i_start     = 1'b0;
    bus.i_sym_valid = 1'b0;
`ifdef VITERBI_CTRL_ABORT_EN
    bus.i_abort     = 1'b0;
`endif
    if (abort_at < 0) begin end
    repeat (2) @(negedge clk);
    chk("strobe_pending", sq.size(), 0);
    chk("tb_pending", tq.size(), 0);
    chk("init_pending", iq.size(), 0);
    chk("done_pending", dq.size(), 0);
  endtask

  task automatic push_normal(input int b);
    iq.push_back(b + 1);
    push_strobe(b + 3, 2'b00, 2'd0);
    push_strobe(b + 4, 2'b01, 2'd1);
    push_strobe(b + 5, 2'b10, 2'd2);
    push_strobe(b + 6, 2'b11, 2'd3);
    push_tb(b + 7, 2'd3);
    push_tb(b + 8, 2'd2);
    push_tb(b + 9, 2'd1);
    push_tb(b + 10, 2'd0);
    dq.push_back(b + 11);
  endtask

  initial begin
    int base;
    bus.i_start     = 1'b0;
    bus.i_sym_valid = 1'b0;
    bus.i_sym       = 2'b00;
`ifdef VITERBI_CTRL_ABORT_EN
    bus.i_abort     = 1'b0;
`endif
    @(negedge clk);
    chk("reset_outs", int'(outs()), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_outs", int'(outs()), 0);
    end

    // Continuous valid, symbols 00,01,10,11; valid also high in the i_start cycle.
    base = cyc;
    push_normal(base);
    run_frame(32'hFFFF_FFFF, -1, -1, -1, 1'b0, 16);

    // Valid dropped for cycles 4 and 5: strobes slip, done two cycles later.
    @(negedge clk);
    base = cyc;
    iq.push_back(base + 1);
    push_strobe(base + 3, 2'b00, 2'd0);
    push_strobe(base + 4, 2'b01, 2'd1);
    push_strobe(base + 7, 2'b10, 2'd2);
    push_strobe(base + 8, 2'b11, 2'd3);
    push_tb(base + 9, 2'd3);
    push_tb(base + 10, 2'd2);
    push_tb(base + 11, 2'd1);
    push_tb(base + 12, 2'd0);
    dq.push_back(base + 13);
    run_frame(32'hFFFF_FFCF, -1, -1, -1, 1'b1, 16);

    // i_start re-pulsed during traceback with valid held high: no effect.
    @(negedge clk);
    base = cyc;
    push_normal(base);
    run_frame(32'hFFFF_FFFF, 8, -1, -1, 1'b0, 18);

    // Reset after two accepted symbols: outputs drop at once, frame discarded.
    @(negedge clk);
    base = cyc;
    iq.push_back(base + 1);
    push_strobe(base + 3, 2'b00, 2'd0);
    run_frame(32'hFFFF_FFFF, -1, -1, 3, 1'b0, 16);
    chk("post_rst_outs", int'(outs()), 0);

    // Fresh frame after reset restarts addresses at 0.
    @(negedge clk);
    base = cyc;
    push_normal(base);
    run_frame(32'hFFFF_FFFF, -1, -1, -1, 1'b0, 16);

`ifdef VITERBI_CTRL_ABORT_EN
    // Abort in traceback cycle 8: back to IDLE, no further tb cycles, no done.
    @(negedge clk);
    base = cyc;
    iq.push_back(base + 1);
    push_strobe(base + 3, 2'b00, 2'd0);
    push_strobe(base + 4, 2'b01, 2'd1);
    push_strobe(base + 5, 2'b10, 2'd2);
    push_strobe(base + 6, 2'b11, 2'd3);
    push_tb(base + 7, 2'd3);
    push_tb(base + 8, 2'd2);
    run_frame(32'h0000_FFFF, -1, 8, -1, 1'b0, 16);
    chk("abort_idle_busy", int'(bus.o_busy), 0);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/viterbi_ctrl.md
# viterbi_ctrl

Frame-level sequencer for the Viterbi decoder datapath. Accepts 2-bit received symbols over a valid/ready handshake and drives the Branch_metric_unit input with one registered symbol per accepted transfer. Issues the ACS update strobes and survivor-memory write addresses, then runs the traceback read phase and signals frame completion. Sits between the symbol source and the BMU/ACS/survivor-memory/traceback datapath.

## Interface
Parameters:
- FRAME_LEN, 16: symbols per frame, must be ≥2
- ADDR_W, $clog2(FRAME_LEN): survivor-memory address width

Ports (one clock; reset is asynchronous and active-high):
- i_clk  in  1  clock, all state updates on the rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  begin frame; sampled only in IDLE
- i_sym_valid  in  1  i_sym valid
- i_sym  in  2  received code symbol {c1,c0}
- o_sym_ready  out  1  controller accepts a symbol this cycle
- o_bmu_data  out  2  registered symbol to Branch_metric_unit i_data
- o_acs_init  out  1  one-cycle pulse to clear the path metrics
- o_acs_en  out  1  ACS update strobe, one per accepted symbol
- o_sm_wr_en  out  1  survivor-memory write enable (equals o_acs_en)
- o_sm_addr  out  ADDR_W  survivor-memory write address (ACS) or read address (TB)
- o_tb_en  out  1  traceback active; o_sm_addr is the read address
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse at frame end

## Operation
- States: IDLE → INIT → ACS → DRAIN → TB → DONE → IDLE.
- IDLE: i_start=1 → INIT. The controller holds o_sym_ready=0.
- INIT (1 cycle): o_acs_init=1, the symbol counter clears to 0, then → ACS.
- ACS: o_sym_ready = (cnt < FRAME_LEN). A handshake (i_sym_valid & o_sym_ready) at edge k registers i_sym into o_bmu_data. In cycle k+1: o_acs_en=o_sm_wr_en=1 and o_sm_addr=cnt value at acceptance. cnt then increments.
- Handshake with cnt==FRAME_LEN-1 → DRAIN. DRAIN lasts 1 cycle with o_sym_ready=0 and carries the strobe for the last symbol. Then → TB.
- TB: o_tb_en=1. o_sm_addr loads FRAME_LEN-1 and decrements once per cycle down to 0, for FRAME_LEN cycles. → DONE.
- DONE (1 cycle): o_done=1, then → IDLE.
- Valid gaps in ACS: no strobe is issued, o_bmu_data holds its last value, and the address does not advance.
- Arithmetic: cnt is ADDR_W+1 bits wide. The address never wraps. Reaching FRAME_LEN ends the accept phase.

## Timing
- Reset values: all outputs 0, o_bmu_data=2'b00, state IDLE, cnt=0.
- Latency: symbol accept → o_bmu_data/o_acs_en is 1 cycle.
- With continuous valid and i_start sampled at edge 0, FRAME_LEN=4: INIT cycle 1, accepts cycles 2–5, strobes cycles 3–6 (DRAIN=6), TB cycles 7–10 (addr 3,2,1,0), o_done cycle 11.
- i_start while busy is ignored. i_sym_valid in any state other than ACS is ignored (not accepted).
- i_start and i_sym_valid in the same IDLE cycle: the symbol is not accepted.
- Reset asserted mid-frame: outputs return to reset values immediately (asynchronously). A partial frame is discarded and no o_done is issued.

## Configuration
- VITERBI_CTRL_ABORT_EN defined: adds the port i_abort (in, 1).
  - i_abort=1 in any state except IDLE or DONE → IDLE at the next edge.
  - All strobes are 0 from that edge, and o_done is not pulsed.
  - i_abort has priority over a simultaneous handshake, which is then not accepted.
- VITERBI_CTRL_ABORT_EN undefined: the i_abort port is absent and a frame always runs to DONE.

## Structure
- Package viterbi_pkg: SYM_W=2, NUM_STATES=4 (trellis states), the controller state enum typedef, and the symbol typedef logic [SYM_W-1:0].
- Sub-module viterbi_addr_cnt: ADDR_W-wide counter with synchronous clear, load, up and down controls. It produces o_sm_addr and the terminal-count flags.

## Test plan
- Reset, then idle for 5 cycles → all outputs 0, o_sym_ready=0, o_busy=0.
- FRAME_LEN=4, start, symbols 00,01,10,11 with continuous valid → o_acs_init in cycle 1. o_bmu_data=00,01,10,11 with o_acs_en and o_sm_addr=0..3 in cycles 3–6. o_tb_en with addr 3,2,1,0 in cycles 7–10. o_done in cycle 11.
- Valid dropped for 2 cycles after the second symbol → no strobes during the gap, o_bmu_data holds 01, and o_done is delayed 2 cycles.
- i_start pulsed during TB, and i_sym_valid held high during INIT/TB → no effect: still exactly 4 strobes and one o_done.
- i_rst asserted during ACS after 2 symbols → outputs 0 at once. A new frame then completes normally with addresses starting at 0.
- With VITERBI_CTRL_ABORT_EN, i_abort in TB cycle 8 → IDLE at the next edge, o_tb_en=0, no o_done.
